// File: rtl/wb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_mem
// Description : Pipelined Wishbone B4 slave memory with fixed response
//               latency, bounded outstanding requests, optional periodic
//               stall injection and address-range error responses.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_slave_mem #(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int MEM_AW           = 10,
    parameter int LATENCY          = 2,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int STALL_PERIOD     = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cyc,
    input  logic                          stb,
    input  logic                          we,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   addr,
    input  logic [C_AXI_DATA_WIDTH-1:0]   indata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] sel,
    output logic                          ack,
    output logic                          stall,
    output logic [C_AXI_DATA_WIDTH-1:0]   outdata,
    output logic                          err
);

    localparam int         NB      = C_AXI_DATA_WIDTH / 8;
    localparam int         LSB     = $clog2(NB);
    localparam int         DEPTH   = 1 << MEM_AW;
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    logic [C_AXI_DATA_WIDTH-1:0] mem [DEPTH];
    logic [MEM_AW-1:0]           word_idx;
    logic                        out_of_range;
    logic                        accept;
    logic                        inject;
    logic [3:0]                  outstanding;
    logic [LATENCY-1:0]          pipe_valid;
    logic [LATENCY-1:0]          pipe_err;
    logic [C_AXI_DATA_WIDTH-1:0] pipe_data [LATENCY];
    logic                        last_valid;
    logic                        unused_addr_lsb;

    assign word_idx        = addr[MEM_AW+LSB-1:LSB];
    assign unused_addr_lsb = ^addr[LSB-1:0];

    generate
        if (C_AXI_ADDR_WIDTH > MEM_AW + LSB) begin : g_range_check
            assign out_of_range = |addr[C_AXI_ADDR_WIDTH-1:MEM_AW+LSB];
        end else begin : g_no_range_check
            assign out_of_range = 1'b0;
        end
    endgenerate

    // Stall depends on registers only, so accept has no input-to-stall loop.
    assign stall  = (outstanding == MAX_CNT) | inject;
    assign accept = cyc & stb & ~stall;

    always_ff @(posedge clk) begin
        if (reset && accept && we && !out_of_range) begin
            for (int i = 0; i < NB; i++) begin
                if (sel[i]) begin
                    mem[word_idx][8*i +: 8] <= indata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || !cyc) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Payload stages need no reset: they are qualified by pipe_valid.
    always_ff @(posedge clk) begin
        pipe_err[0]  <= out_of_range;
        pipe_data[0] <= (we || out_of_range) ? '0 : mem[word_idx];
        for (int i = 1; i < LATENCY; i++) begin
            pipe_err[i]  <= pipe_err[i-1];
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    assign last_valid = pipe_valid[LATENCY-1];
    assign ack        = last_valid & ~pipe_err[LATENCY-1] & cyc;
    assign err        = last_valid &  pipe_err[LATENCY-1] & cyc;
    assign outdata    = ack ? pipe_data[LATENCY-1] : '0;

    always_ff @(posedge clk) begin
        if (!reset || !cyc) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + {3'b000, accept} - {3'b000, last_valid};
        end
    end

    generate
        if (STALL_PERIOD == 0) begin : g_no_inject
            assign inject = 1'b0;
        end else begin : g_inject
            localparam int             SCW        = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
            localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_PERIOD - 1);
            logic [SCW-1:0] stall_cnt;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    stall_cnt <= '0;
                end else if (stall_cnt == STALL_LAST) begin
                    stall_cnt <= '0;
                end else begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end

            assign inject = (stall_cnt == STALL_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_slave_mem
// Description : Scoreboard bench for wb_slave_mem across three parameter sets
//               sharing one stimulus bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_slave_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] indata = '0;
    logic [3:0]  sel = '0;

    logic        ack0, stall0, err0;
    logic        ack1, stall1, err1;
    logic        ack2, stall2, err2;
    logic [31:0] out0, out1, out2;

    logic        ack_s, stall_s, err_s;
    logic [31:0] outdata_s;
    int          lat_s;
    int          dut_sel = 0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;
    int since_rst = 0;

    typedef struct {
        int          due;
        bit          is_err;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [31:0] model_mem [int];

    always #5 clk = ~clk;

    wb_slave_mem u_def (
        .clk(clk), .reset(reset), .cyc(cyc), .stb(stb), .we(we), .addr(addr),
        .indata(indata), .sel(sel), .ack(ack0), .stall(stall0), .outdata(out0), .err(err0)
    );

    wb_slave_mem #(.LATENCY(6), .MAX_OUTSTANDING(4)) u_bp (
        .clk(clk), .reset(reset), .cyc(cyc), .stb(stb), .we(we), .addr(addr),
        .indata(indata), .sel(sel), .ack(ack1), .stall(stall1), .outdata(out1), .err(err1)
    );

    wb_slave_mem #(.STALL_PERIOD(3)) u_stl (
        .clk(clk), .reset(reset), .cyc(cyc), .stb(stb), .we(we), .addr(addr),
        .indata(indata), .sel(sel), .ack(ack2), .stall(stall2), .outdata(out2), .err(err2)
    );

    always_comb begin
        ack_s = ack0; stall_s = stall0; err_s = err0; outdata_s = out0; lat_s = 2;
        if (dut_sel == 1) begin
            ack_s = ack1; stall_s = stall1; err_s = err1; outdata_s = out1; lat_s = 6;
        end else if (dut_sel == 2) begin
            ack_s = ack2; stall_s = stall2; err_s = err2; outdata_s = out2; lat_s = 2;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    // Cycle bookkeeping advances on the active edge; all sampling is at negedge.
    always @(posedge clk) begin
        cyc_no++;
        since_rst = !reset ? 1 : since_rst + 1;
    end

    always @(negedge clk) begin
        if (!cyc) begin
            check("idle_quiet", {30'b0, ack_s, err_s}, 32'h0);
            sb.delete();
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc_no) begin
                mon_e = sb.pop_front();
                check("resp_ack", {31'b0, ack_s}, {31'b0, !mon_e.is_err});
                check("resp_err", {31'b0, err_s}, {31'b0, mon_e.is_err});
                if (mon_e.chk) check("resp_data", outdata_s, mon_e.data);
            end else begin
                check("no_resp", {30'b0, ack_s, err_s}, 32'h0);
            end
            if (!reset) begin
                sb.delete();
            end else if (stb && !stall_s) begin
                mon_e.due    = cyc_no + lat_s;
                mon_e.is_err = |addr[31:12];
                mon_e.chk    = 1'b0;
                mon_e.data   = '0;
                if (mon_e.is_err) begin
                    mon_e.chk = 1'b1;
                end else if (we) begin
                    if (model_mem.exists(int'(addr[11:2])) || sel == 4'hF) begin
                        logic [31:0] w;
                        w = model_mem.exists(int'(addr[11:2])) ? model_mem[int'(addr[11:2])] : 32'h0;
                        for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = indata[8*b +: 8];
                        model_mem[int'(addr[11:2])] = w;
                    end
                end else if (model_mem.exists(int'(addr[11:2]))) begin
                    mon_e.chk  = 1'b1;
                    mon_e.data = model_mem[int'(addr[11:2])];
                end
                sb.push_back(mon_e);
            end
        end
    end

    task automatic reset_pulse(input int which);
        reset = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        dut_sel = which;
        model_mem.delete();
        reset = 1'b1;
    endtask

    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit done = 1'b0;
        int g = 0;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; indata = d; sel = s;
        while (!done && g < 50) begin
            @(negedge clk);
            done = !stall_s;
            g++;
            @(posedge clk); #1;
        end
        stb = 1'b0;
        if (!done) check("req_timeout", 32'h0, 32'h1);
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() > 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_empty", sb.size(), 32'h0);
    endtask

    task automatic read_stream(input int n, input logic [31:0] base, input bit chk_bp, input bit chk_inj);
        int acc = 0;
        int acks = 0;
        int g = 0;
        bit saw_ack = 1'b0;
        bit after_ack = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; addr = base;
        while ((acc < n || sb.size() > 0) && g < 300) begin
            @(negedge clk);
            g++;
            if (chk_bp && acc < 4) check("bp_stall_lo", {31'b0, stall_s}, 32'h0);
            if (chk_bp && acc == 4 && !saw_ack) check("bp_stall_hi", {31'b0, stall_s}, 32'h1);
            if (after_ack) begin
                check("bp_stall_release", {31'b0, stall_s}, 32'h0);
                after_ack = 1'b0;
            end
            if (chk_inj)
                check("inject_stall", {31'b0, stall_s},
                      {31'b0, (since_rst >= 1) && ((since_rst - 1) % 3 == 2)});
            if (ack_s) begin
                acks++;
                if (!saw_ack) begin
                    saw_ack = 1'b1;
                    after_ack = chk_bp;
                end
            end
            if (stb && !stall_s) acc++;
            @(posedge clk); #1;
            if (acc >= n) stb = 1'b0;
            else addr = base + 32'(4 * acc);
        end
        check("stream_done", {31'b0, (acc == n) && (sb.size() == 0)}, 32'h1);
        check("ack_count", acks, acc);
    endtask

    initial begin
        repeat (3) begin @(posedge clk); #1; end
        check("rst_ack0", {31'b0, ack0}, 0);  check("rst_err0", {31'b0, err0}, 0);
        check("rst_stall0", {31'b0, stall0}, 0); check("rst_out0", out0, 0);
        check("rst_ack1", {31'b0, ack1}, 0);  check("rst_err1", {31'b0, err1}, 0);
        check("rst_stall1", {31'b0, stall1}, 0); check("rst_out1", out1, 0);
        check("rst_ack2", {31'b0, ack2}, 0);  check("rst_err2", {31'b0, err2}, 0);
        check("rst_stall2", {31'b0, stall2}, 0); check("rst_out2", out2, 0);

        // Basic write/read, byte lanes, sel=0 no-op and out-of-range.
        reset_pulse(0);
        do_req(1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(0, 32'h10, 32'h0, 4'hF);
        do_req(1, 32'h20, 32'h11223344, 4'hF);
        do_req(1, 32'h20, 32'hAABBCCDD, 4'h5);
        do_req(0, 32'h20, 32'h0, 4'hF);
        do_req(1, 32'h10, 32'h12345678, 4'h0);
        do_req(0, 32'h10, 32'h0, 4'hF);
        do_req(1, 32'h0, 32'hCAFEF00D, 4'hF);
        do_req(0, 32'h1000, 32'h0, 4'hF);
        do_req(1, 32'h1000, 32'h55, 4'hF);
        do_req(0, 32'h0, 32'h0, 4'hF);
        drain();

        // Backpressure at MAX_OUTSTANDING with long latency.
        reset_pulse(1);
        for (int i = 0; i < 8; i++) do_req(1, 32'(4 * i), 32'hA5000000 + 32'(i * 17), 4'hF);
        drain();
        read_stream(8, 32'h0, 1'b1, 1'b0);

        // Periodic stall injection.
        reset_pulse(2);
        for (int i = 0; i < 8; i++) do_req(1, 32'(4 * i), 32'h3C000000 + 32'(i * 5), 4'hF);
        drain();
        read_stream(8, 32'h0, 1'b0, 1'b1);

        // Abort with reads in flight, then restart from zero outstanding.
        reset_pulse(1);
        for (int i = 0; i < 4; i++) do_req(1, 32'h40 + 32'(4 * i), 32'h77000000 + 32'(i), 4'hF);
        drain();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h40;
        @(posedge clk); #1;
        addr = 32'h44;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_quiet", {30'b0, ack_s, err_s}, 32'h0);
            @(posedge clk); #1;
            if (i == 2) cyc = 1'b1;
        end
        read_stream(4, 32'h40, 1'b1, 1'b0);

        // Reset during an in-flight write: response dropped, write kept.
        do_req(1, 32'h60, 32'h0BADF00D, 4'hF);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstmid_ack", {31'b0, ack_s}, 0);
        check("rstmid_err", {31'b0, err_s}, 0);
        check("rstmid_stall", {31'b0, stall_s}, 0);
        check("rstmid_out", outdata_s, 0);
        reset = 1'b1;
        do_req(0, 32'h60, 32'h0, 4'hF);
        drain();
        cyc = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
